// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the dual-write multi-port register file.
// Build option: REG_FILE_MP_BYPASS_EN enables write-to-read forwarding.
package reg_file_mp_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int DEF_DEPTH = depth_of(DEF_ADDR_W);

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: two write ports, one paired read,
// reservation request and busy scoreboard.
interface reg_file_mp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    localparam int DEPTH = 1 << ADDR_W;

    logic              we1;
    logic              we2;
    logic [ADDR_W-1:0] wa1;
    logic [ADDR_W-1:0] wa2;
    logic [DATA_W-1:0] wd1;
    logic [DATA_W-1:0] wd2;
    logic              re;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rvalid;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic [DEPTH-1:0]  busy;

    modport master (
        output we1, we2, wa1, wa2, wd1, wd2,
        output re, ra1, ra2, rsv_en, rsv_addr,
        input  rd1, rd2, rvalid, busy
    );

    modport slave (
        input  we1, we2, wa1, wa2, wd1, wd2,
        input  re, ra1, ra2, rsv_en, rsv_addr,
        output rd1, rd2, rvalid, busy
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Busy scoreboard: reserve sets a bit, any write clears it,
// and a reserve on the same edge as a write wins.
module reg_file_mp_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    localparam int DEPTH   = depth_of(ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] wa2,
    output logic [DEPTH-1:0]  busy
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < DEPTH; i++) begin
            if ((we1 && wa1 == ADDR_W'(i)) ||
                (we2 && wa2 == ADDR_W'(i)))
                w_busy_nxt[i] = 1'b0;
            if (rsv_en && rsv_addr == ADDR_W'(i))
                w_busy_nxt[i] = 1'b1;
        end
        if (ZERO_REG != 0)
            w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign busy = r_busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 write ports (port 2 wins), registered dual read,
// busy scoreboard. Build option: REG_FILE_MP_BYPASS_EN forwards same-cycle writes.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    localparam int DEPTH   = depth_of(ADDR_W)
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_mp_if.slave bus
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_rvalid;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DEPTH-1:0]  w_busy;

    function automatic logic [DATA_W-1:0] rd_val(
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        v = r_mem[a];
`ifdef REG_FILE_MP_BYPASS_EN
        if (bus.we2 && bus.wa2 == a)
            v = bus.wd2;
        else if (bus.we1 && bus.wa1 == a)
            v = bus.wd1;
`endif
        if (ZERO_REG != 0 && a == '0)
            v = '0;
        return v;
    endfunction

    always_comb begin
        w_rd1 = rd_val(bus.ra1);
        w_rd2 = rd_val(bus.ra2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ZERO_REG != 0 && i == 0)
                    r_mem[i] <= '0;
                else if (bus.we2 && bus.wa2 == ADDR_W'(i))
                    r_mem[i] <= bus.wd2;
                else if (bus.we1 && bus.wa1 == ADDR_W'(i))
                    r_mem[i] <= bus.wd1;
            end
        end
    end

    // Read data holds between requests; rvalid marks only fresh data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd1    <= '0;
            r_rd2    <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= bus.re;
            if (bus.re) begin
                r_rd1 <= w_rd1;
                r_rd2 <= w_rd2;
            end
        end
    end

    reg_file_mp_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .we1      (bus.we1),
        .wa1      (bus.wa1),
        .we2      (bus.we2),
        .wa2      (bus.wa2),
        .busy     (w_busy)
    );

    assign bus.rd1    = r_rd1;
    assign bus.rd2    = r_rd2;
    assign bus.rvalid = r_rvalid;
    assign bus.busy   = w_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: dut_a default, dut_z with ZERO_REG=1,
// both fed the same stimulus.
module tb_reg_file_mp;

    logic clk;
    logic rst_n;

    logic       we1, we2, re, rsv_en;
    logic [1:0] wa1, wa2, ra1, ra2, rsv_addr;
    logic [7:0] wd1, wd2;

    int n_tot;
    int n_bad;

    reg_file_mp_if #(.DATA_W(8), .ADDR_W(2)) ia ();
    reg_file_mp_if #(.DATA_W(8), .ADDR_W(2)) iz ();

    assign ia.we1 = we1;   assign iz.we1 = we1;
    assign ia.we2 = we2;   assign iz.we2 = we2;
    assign ia.wa1 = wa1;   assign iz.wa1 = wa1;
    assign ia.wa2 = wa2;   assign iz.wa2 = wa2;
    assign ia.wd1 = wd1;   assign iz.wd1 = wd1;
    assign ia.wd2 = wd2;   assign iz.wd2 = wd2;
    assign ia.re  = re;    assign iz.re  = re;
    assign ia.ra1 = ra1;   assign iz.ra1 = ra1;
    assign ia.ra2 = ra2;   assign iz.ra2 = ra2;
    assign ia.rsv_en   = rsv_en;
    assign iz.rsv_en   = rsv_en;
    assign ia.rsv_addr = rsv_addr;
    assign iz.rsv_addr = rsv_addr;

    reg_file_mp #(
        .DATA_W(8), .ADDR_W(2), .ZERO_REG(0)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    reg_file_mp #(
        .DATA_W(8), .ADDR_W(2), .ZERO_REG(1)
    ) dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (iz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we1 = 0; we2 = 0; re = 0; rsv_en = 0;
        wa1 = 0; wa2 = 0; ra1 = 0; ra2 = 0; rsv_addr = 0;
        wd1 = 0; wd2 = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_byp1;
    logic [7:0] exp_byp0;

    initial begin
        n_tot = 0;
        n_bad = 0;
`ifdef REG_FILE_MP_BYPASS_EN
        exp_byp1 = 8'h55;
        exp_byp0 = 8'h44;
`else
        exp_byp1 = 8'h10;
        exp_byp0 = 8'h00;
`endif
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rd1", ia.rd1, 0);
        chk("rst_rvalid", ia.rvalid, 0);
        chk("rst_busy", ia.busy, 0);
        #10 rst_n = 1'b1;
        step();

        // write then read
        we1 = 1; wa1 = 2; wd1 = 8'hA5;
        step();
        idle();
        re = 1; ra1 = 2; ra2 = 1;
        step();
        chk("wr_rd1", ia.rd1, 8'hA5);
        chk("wr_rd2", ia.rd2, 8'h00);
        chk("wr_rvalid", ia.rvalid, 1);
        chk("z_wr_rd1", iz.rd1, 8'hA5);
        idle();
        step();
        chk("rvalid_drop", ia.rvalid, 0);
        chk("rd1_hold", ia.rd1, 8'hA5);

        // same-address double write
        we1 = 1; wa1 = 3; wd1 = 8'h11;
        we2 = 1; wa2 = 3; wd2 = 8'h22;
        step();
        idle();
        re = 1; ra1 = 3; ra2 = 2;
        step();
        chk("conf_rd1", ia.rd1, 8'h22);
        chk("conf_rd2", ia.rd2, 8'hA5);

        // read during write
        idle();
        we1 = 1; wa1 = 1; wd1 = 8'h10;
        step();
        we1 = 1; wa1 = 1; wd1 = 8'h55;
        re = 1; ra1 = 1; ra2 = 3;
        step();
        chk("byp_rd1", ia.rd1, exp_byp1);
        chk("byp_rd2", ia.rd2, 8'h22);
        idle();
        we1 = 1; wa1 = 0; wd1 = 8'h33;
        we2 = 1; wa2 = 0; wd2 = 8'h44;
        re = 1; ra1 = 0; ra2 = 1;
        step();
        chk("byp_p2_rd1", ia.rd1, exp_byp0);
        chk("byp_after_rd2", ia.rd2, 8'h55);
        chk("z_byp_rd1", iz.rd1, 8'h00);

        // scoreboard
        idle();
        rsv_en = 1; rsv_addr = 2;
        step();
        chk("sb_rsv2", ia.busy, 4'b0100);
        idle();
        we2 = 1; wa2 = 2; wd2 = 8'h77;
        step();
        chk("sb_clr2", ia.busy, 4'b0000);
        idle();
        rsv_en = 1; rsv_addr = 1;
        we1 = 1; wa1 = 1; wd1 = 8'h66;
        step();
        chk("sb_rsv_wr", ia.busy, 4'b0010);
        idle();
        we1 = 1; wa1 = 3; wd1 = 8'h99;
        re = 1; ra1 = 1; ra2 = 2;
        step();
        chk("sb_data1", ia.rd1, 8'h66);
        chk("sb_data2", ia.rd2, 8'h77);
        chk("sb_nonbusy", ia.busy, 4'b0010);

        // register 0 on the ZERO_REG instance
        idle();
        we1 = 1; wa1 = 0; wd1 = 8'hFF;
        rsv_en = 1; rsv_addr = 0;
        step();
        chk("z_busy", iz.busy, 4'b0010);
        chk("a_busy", ia.busy, 4'b0011);
        idle();
        re = 1; ra1 = 0; ra2 = 3;
        step();
        chk("z_rd0", iz.rd1, 8'h00);
        chk("a_rd0", ia.rd1, 8'hFF);
        chk("a_rd3", ia.rd2, 8'h99);

        // mid-cycle reset with a write and read pending
        idle();
        we1 = 1; wa1 = 3; wd1 = 8'hEE;
        re = 1; ra1 = 0; ra2 = 3;
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_rd1", ia.rd1, 0);
        chk("mrst_rd2", ia.rd2, 0);
        chk("mrst_rvalid", ia.rvalid, 0);
        chk("mrst_busy", ia.busy, 0);
        #1 rst_n = 1'b1;
        idle();
        re = 1; ra1 = 3; ra2 = 0;
        step();
        chk("post_rst_rd1", ia.rd1, 8'h00);
        chk("post_rst_rvalid", ia.rvalid, 1);
        idle();
        we2 = 1; wa2 = 2; wd2 = 8'h3C;
        step();
        idle();
        re = 1; ra1 = 2;
        step();
        chk("post_rst_wr", ia.rd1, 8'h3C);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits (SHALL be >= 1).
REQ-002 Parameter ADDR_W, default 2, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 SHALL always read 0 and ignore writes and reservations.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 we1 / we2  input  1 each  write enables, ports 1 and 2.
REQ-007 wa1 / wa2  input  ADDR_W each  write addresses.
REQ-008 wd1 / wd2  input  DATA_W each  write data.
REQ-009 re  input  1  read request; samples ra1 and ra2 together.
REQ-010 ra1 / ra2  input  ADDR_W each  read addresses.
REQ-011 rd1 / rd2  output  DATA_W each  registered read data.
REQ-012 rvalid  output  1  high for exactly one cycle when rd1/rd2 carry new data.
REQ-013 rsv_en  input  1  reserve request: marks register rsv_addr busy.
REQ-014 rsv_addr  input  ADDR_W  register to reserve.
REQ-015 busy  output  DEPTH  registered scoreboard; bit i set means register i awaits writeback.

Function
REQ-016 A write with weN=1 SHALL update register waN with wdN at the rising edge.
REQ-017 If we1 and we2 both target the same address in one cycle, port 2 data SHALL win.
REQ-018 A read with re=1 in cycle N SHALL present rd1 = reg[ra1] and rd2 = reg[ra2] in cycle N+1, with rvalid=1 in cycle N+1 only.
REQ-019 With re=0, rd1/rd2 SHALL hold their previous values and rvalid SHALL be 0.
REQ-020 rsv_en=1 SHALL set busy[rsv_addr] at the edge; any write to address A SHALL clear busy[A] at the edge.
REQ-021 A simultaneous reserve and write to the same address SHALL write the data and leave busy set.
REQ-022 A write to a non-busy register SHALL be legal and SHALL leave busy clear.
REQ-023 With ZERO_REG=1, rd for address 0 SHALL be 0 and busy[0] SHALL stay 0.
REQ-024 Addresses SHALL cover exactly DEPTH entries; no out-of-range case exists.

Reset
REQ-025 While rst_n=0, all registers, rd1, rd2, rvalid and busy SHALL be 0 immediately, without waiting for clk.
REQ-026 A read or write in flight when reset asserts SHALL be discarded; the first edge after deassertion SHALL operate normally.

Configuration
REQ-027 Macro REG_FILE_MP_BYPASS_EN: when defined, a read whose address matches an active write in the same cycle SHALL return the new write data (port 2 priority per REQ-017).
REQ-028 Without REG_FILE_MP_BYPASS_EN, such a read SHALL return the pre-write register contents.

Structure
REQ-029 Package reg_file_mp_pkg SHALL hold the DATA_W/ADDR_W defaults and a DEPTH-from-ADDR_W helper constant.
REQ-030 The busy scoreboard SHALL be a sub-module reg_file_mp_scoreboard (inputs: rsv_en, rsv_addr, we1/wa1, we2/wa2; output: busy).

Verification
REQ-031 Reset: rst_n=0 asynchronously mid-cycle -> rd1=rd2=0, rvalid=0, busy=0 before the next edge.
REQ-032 Write/read: we1, wa1=2, wd1=8'hA5; next cycle re, ra1=2, ra2=1 -> following cycle rd1=8'hA5, rd2=8'h00, rvalid=1 for one cycle.
REQ-033 Write conflict: we1 wa1=3 wd1=8'h11 and we2 wa2=3 wd2=8'h22 together -> later read of 3 returns 8'h22.
REQ-034 Bypass: reg1=8'h10; same cycle we1 wa1=1 wd1=8'h55 and re ra1=1 -> rd1=8'h55 with macro, 8'h10 without.
REQ-035 Scoreboard: rsv_en rsv_addr=2 -> busy=4'b0100; later we2 wa2=2 -> busy=4'b0000; rsv_en and we1 both at address 1 -> busy[1]=1 and data written.
REQ-036 ZERO_REG=1: we1 wa1=0 wd1=8'hFF plus rsv_en rsv_addr=0 -> read of 0 returns 8'h00 and busy[0]=0.
